// File: rtl/ntt_pkg.sv
// Shared NTT datapath helpers: row/address geometry, the BRAM latency default
// and the cross-PE gap index mapping used by the operand regroup logic.
package ntt_pkg;

  localparam int RAM_LAT_DEFAULT = 1;

  function automatic int rows_of(int logn, int pe);
    return (1 << logn) / 2 / pe;
  endfunction

  // Kept at least 1 bit wide so a single-row bank still has a legal address bus.
  function automatic int aw_of(int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // k-th index i with (i & gap) == 0: insert a zero bit at the gap position.
  function automatic int unsigned gap_index(int unsigned k, int unsigned gap);
    int unsigned lo;
    lo = k & (gap - 1);
    return ((k - lo) << 1) | lo;
  endfunction

endpackage

// File: rtl/bf_operand_fetcher_if.sv
// BRAM read port plus butterfly operand stream of the operand fetcher.
interface bf_operand_fetcher_if #(
  parameter int LOGQ = 16,
  parameter int PE   = 2,
  parameter int AW   = 2
);
  logic                            ren;
  logic [AW-1:0]                   raddr;
  logic [PE-1:0][1:0][LOGQ-1:0]    rdata;
  logic                            bf_valid;
  logic [AW-1:0]                   bf_rd_addr;
  logic [PE-1:0][1:0][LOGQ-1:0]    bf_data;

  modport master (
    output ren, raddr, bf_valid, bf_rd_addr, bf_data,
    input  rdata
  );

  modport slave (
    input  ren, raddr, bf_valid, bf_rd_addr, bf_data,
    output rdata
  );
endinterface

// File: rtl/bf_gap_permute.sv
// Combinational regroup of a flattened BRAM row into PE operand pairs that sit
// `gap` words apart; gap = 1 is the identity.
module bf_gap_permute
  import ntt_pkg::*;
#(
  parameter int LOGQ = 16,
  parameter int PE   = 2
) (
  input  logic [$clog2(PE):0]             gap,
  input  logic [PE-1:0][1:0][LOGQ-1:0]    din,
  output logic [PE-1:0][1:0][LOGQ-1:0]    dout
);

  localparam int IW = $clog2(2 * PE);

  logic [2*PE-1:0][LOGQ-1:0] w;
  int unsigned               g;
  int unsigned               ia;
  int unsigned               ib;

  assign w = din;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    dout = '0;
    g    = 32'(gap);
    ia   = 0;
    ib   = 0;
    for (int k = 0; k < PE; k++) begin
      ia = gap_index(unsigned'(k), g);
      ib = ia + g;
      // Illegal gaps simply wrap the index; the data is don't-care then.
      dout[k][0] = w[ia[IW-1:0]];
      dout[k][1] = w[ib[IW-1:0]];
    end
  end

endmodule

// File: rtl/bf_operand_fetcher.sv
// Issues row reads for one NTT stage, regroups the returned rows and undoes the
// two-beat write interleave, tagging each operand beat with its row address.
module bf_operand_fetcher
  import ntt_pkg::*;
#(
  // No meaningful defaults exist; instantiate with explicit values.
  parameter int LOGQ    = 16,
  parameter int LOGN    = 4,
  parameter int PE      = 2,
  parameter int RAM_LAT = RAM_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  ident_load,
  input  logic [$clog2(PE):0]   src_gap,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  bf_operand_fetcher_if.master  bus
);

  localparam int ROWS = rows_of(LOGN, PE);
  localparam int AW   = aw_of(ROWS);
  localparam int GW   = $clog2(PE) + 1;

  localparam logic [AW-1:0] LAST_ROW  = AW'(ROWS - 1);
  localparam logic [AW:0]   LAST_BEAT = (AW + 1)'(ROWS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef logic [PE-1:0][1:0][LOGQ-1:0] bundle_t;

  logic [1:0]    state;
  logic [AW-1:0] row;
  logic [AW:0]   beat_cnt;
  logic          ident_q;
  logic [GW-1:0] gap_q;
  logic          ren;

  logic [RAM_LAT-1:0]         sr_v;
  logic [RAM_LAT-1:0][AW-1:0] sr_row;
  logic                       arr_v;
  logic [AW-1:0]              arr_row;
  bundle_t                    perm;

  bundle_t       buf_a;
  bundle_t       hold_data;
  logic [AW-1:0] hold_row;
  logic          hold_v;
  logic          bf_valid;
  logic [AW-1:0] bf_rd_addr;
  bundle_t       bf_data;

  assign ren       = (state == S_ISSUE) && !stall;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign bus.ren   = ren;
  assign bus.raddr = row;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      row      <= '0;
      beat_cnt <= '0;
      ident_q  <= 1'b0;
      gap_q    <= '0;
    end else begin
      if (bf_valid) beat_cnt <= beat_cnt + 1'b1;
      case (state)
        S_IDLE: if (start) begin
          ident_q  <= ident_load;
          gap_q    <= src_gap;
          row      <= '0;
          beat_cnt <= '0;
          state    <= S_ISSUE;
        end
        S_ISSUE: if (!stall) begin
          row <= row + 1'b1;
          if (row == LAST_ROW) state <= S_DRAIN;
        end
        S_DRAIN: if (bf_valid && beat_cnt == LAST_BEAT) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-valid history aligned with the BRAM latency; carries each row tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_v   <= '0;
      sr_row <= '0;
    end else begin
      sr_v[0]   <= ren;
      sr_row[0] <= row;
      for (int i = 1; i < RAM_LAT; i++) begin
        sr_v[i]   <= sr_v[i-1];
        sr_row[i] <= sr_row[i-1];
      end
    end
  end

  assign arr_v   = sr_v[RAM_LAT-1];
  assign arr_row = sr_row[RAM_LAT-1];

  bf_gap_permute #(
    .LOGQ (LOGQ),
    .PE   (PE)
  ) u_gap_permute (
    .gap  (gap_q),
    .din  (bus.rdata),
    .dout (perm)
  );

  // NOTE: the row buffers are plain registers, so they are cleared on reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_valid   <= 1'b0;
      bf_rd_addr <= '0;
      bf_data    <= '0;
      buf_a      <= '0;
      hold_data  <= '0;
      hold_row   <= '0;
      hold_v     <= 1'b0;
    end else begin
      bf_valid <= 1'b0;
      hold_v   <= 1'b0;
      if (ident_q) begin
        if (arr_v) begin
          bf_valid   <= 1'b1;
          bf_rd_addr <= arr_row;
          bf_data    <= perm;
        end
      end else begin
        if (hold_v) begin
          bf_valid   <= 1'b1;
          bf_rd_addr <= hold_row;
          bf_data    <= hold_data;
        end
        if (arr_v && !arr_row[0]) buf_a <= perm;
        // Odd row completes a pair: emit the even beat now, park the odd one.
        if (arr_v && arr_row[0]) begin
          bf_valid   <= 1'b1;
          bf_rd_addr <= arr_row & ~AW'(1);
          hold_row   <= arr_row;
          hold_v     <= 1'b1;
          for (int p = 0; p < PE; p++) begin
            bf_data[p][0]   <= buf_a[p][0];
            bf_data[p][1]   <= perm[p][0];
            hold_data[p][0] <= buf_a[p][1];
            hold_data[p][1] <= perm[p][1];
          end
        end
      end
    end
  end

  assign bus.bf_valid   = bf_valid;
  assign bus.bf_rd_addr = bf_rd_addr;
  assign bus.bf_data    = bf_data;

endmodule
